// File: rtl/risc_run_monitor_if.sv
// Bus between risc_run_monitor and its driver: run control, observed/expected channels, results.
// first_bad/bad_val exist only when RUN_MON_MISMATCH_EN is defined.
interface risc_run_monitor_if #(
    parameter int NCH = 2,
    parameter int W   = 32,
    parameter int CW  = 16
);
    logic             rerun;
    logic [NCH*W-1:0] obs;
    logic [NCH*W-1:0] exp;
    logic [NCH-1:0]   mask;
    logic             dut_rst;
    logic             busy;
    logic             done;
    logic             pass;
    logic             timeout;
    logic [NCH-1:0]   match;
    logic [CW-1:0]    cycles;

`ifdef RUN_MON_MISMATCH_EN
    localparam int FBW = (NCH > 1) ? $clog2(NCH) : 1;
    logic [FBW-1:0]   first_bad;
    logic [W-1:0]     bad_val;

    modport master (
        output rerun, obs, exp, mask,
        input  dut_rst, busy, done, pass, timeout, match, cycles, first_bad, bad_val
    );
    modport slave (
        input  rerun, obs, exp, mask,
        output dut_rst, busy, done, pass, timeout, match, cycles, first_bad, bad_val
    );
`else
    modport master (
        output rerun, obs, exp, mask,
        input  dut_rst, busy, done, pass, timeout, match, cycles
    );
    modport slave (
        input  rerun, obs, exp, mask,
        output dut_rst, busy, done, pass, timeout, match, cycles
    );
`endif
endinterface

// File: rtl/risc_run_monitor.sv
// Run controller/result checker for miniRISC: holds core reset, runs until outputs settle, checks them.
// Optional lowest-failing-channel report enabled by defining RUN_MON_MISMATCH_EN.
module risc_run_monitor #(
    parameter int NCH           = 2,
    parameter int W             = 32,
    parameter int RST_CYCLES    = 1,
    parameter int STABLE_CYCLES = 8,
    parameter int MAX_CYCLES    = 50,
    parameter int CW            = 16
) (
    input  logic              clk,
    input  logic              rst,
    risc_run_monitor_if.slave bus
);
    localparam int HW = $clog2(RST_CYCLES + 1);
    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_LAST   = HW'(RST_CYCLES - 1);
    localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] CYC_LAST    = CW'(MAX_CYCLES - 1);

    typedef enum logic [1:0] {RESET_HOLD, RUN, CHECK, DONE} state_e;

    state_e           state_q;
    logic             dut_rst_q, busy_q, done_q, pass_q, timeout_q;
    logic [NCH-1:0]   match_q;
    logic [CW-1:0]    cycles_q;
    logic [HW-1:0]    hold_q;
    logic [SW-1:0]    stable_q;
    logic [NCH*W-1:0] obs_q;

    logic             obs_eq, stable_hit, budget_hit, pass_d;
    logic [SW-1:0]    stable_d;
    logic [CW-1:0]    cycles_d;
    logic [NCH-1:0]   match_d;

`ifdef RUN_MON_MISMATCH_EN
    localparam int FBW = (NCH > 1) ? $clog2(NCH) : 1;
    logic [FBW-1:0]   first_bad_q, first_bad_d;
    logic [W-1:0]     bad_val_q, bad_val_d;
`endif

    // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        obs_eq     = (bus.obs == obs_q);
        stable_d   = obs_eq ? stable_q + SW'(1) : '0;
        stable_hit = obs_eq && (stable_q == STABLE_LAST);
        budget_hit = (cycles_q == CYC_LAST);
        cycles_d   = (cycles_q == '1) ? cycles_q : cycles_q + CW'(1);
        match_d    = '0;
        for (int i = 0; i < NCH; i++) begin
            match_d[i] = ~bus.mask[i] | (bus.obs[i*W +: W] == bus.exp[i*W +: W]);
        end
        pass_d = &match_d;
`ifdef RUN_MON_MISMATCH_EN
        first_bad_d = '0;
        bad_val_d   = '0;
        // Scan downward so the lowest failing channel is the one left standing.
        for (int i = NCH - 1; i >= 0; i--) begin
            if (!match_d[i]) begin
                first_bad_d = FBW'(i);
                bad_val_d   = bus.obs[i*W +: W];
            end
        end
`endif
    end

    // NOTE: obs_q is a pure delay line compared only while running, so it carries no reset.
    always_ff @(posedge clk) begin
        obs_q <= bus.obs;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RESET_HOLD;
            dut_rst_q   <= 1'b1;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            timeout_q   <= 1'b0;
            match_q     <= '0;
            cycles_q    <= '0;
            hold_q      <= '0;
            stable_q    <= '0;
`ifdef RUN_MON_MISMATCH_EN
            first_bad_q <= '0;
            bad_val_q   <= '0;
`endif
        end else begin
            case (state_q)
                RESET_HOLD: begin
                    if (hold_q == HOLD_LAST) begin
                        state_q   <= RUN;
                        dut_rst_q <= 1'b0;
                        hold_q    <= '0;
                    end else begin
                        hold_q <= hold_q + HW'(1);
                    end
                end
                RUN: begin
                    cycles_q <= cycles_d;
                    // Settling takes priority over budget exhaustion on the same edge.
                    if (stable_hit) begin
                        state_q  <= CHECK;
                        stable_q <= '0;
                    end else if (budget_hit) begin
                        state_q   <= DONE;
                        stable_q  <= '0;
                        done_q    <= 1'b1;
                        busy_q    <= 1'b0;
                        timeout_q <= 1'b1;
                    end else begin
                        stable_q <= stable_d;
                    end
                end
                CHECK: begin
                    state_q     <= DONE;
                    done_q      <= 1'b1;
                    busy_q      <= 1'b0;
                    pass_q      <= pass_d;
                    match_q     <= match_d;
`ifdef RUN_MON_MISMATCH_EN
                    first_bad_q <= first_bad_d;
                    bad_val_q   <= bad_val_d;
`endif
                end
                DONE: begin
                    if (bus.rerun) begin
                        state_q     <= RESET_HOLD;
                        dut_rst_q   <= 1'b1;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        pass_q      <= 1'b0;
                        timeout_q   <= 1'b0;
                        match_q     <= '0;
                        cycles_q    <= '0;
                        hold_q      <= '0;
                        stable_q    <= '0;
`ifdef RUN_MON_MISMATCH_EN
                        first_bad_q <= '0;
                        bad_val_q   <= '0;
`endif
                    end
                end
                default: state_q <= RESET_HOLD;
            endcase
        end
    end

    assign bus.dut_rst   = dut_rst_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.timeout   = timeout_q;
    assign bus.match     = match_q;
    assign bus.cycles    = cycles_q;
`ifdef RUN_MON_MISMATCH_EN
    assign bus.first_bad = first_bad_q;
    assign bus.bad_val   = bad_val_q;
`endif
endmodule

// File: tb/tb_risc_run_monitor.sv
// Scoreboard bench for risc_run_monitor: stimulus queues expected results, a monitor checks each done.
// Works with and without RUN_MON_MISMATCH_EN.
module tb_risc_run_monitor;
    localparam int NCH = 2;
    localparam int W   = 32;
    localparam int CW  = 16;

    typedef struct {
        logic        pass;
        logic        timeout;
        logic [1:0]  match;
        logic [15:0] cycles;
        int          done_at;
        logic [0:0]  first_bad;
        logic [31:0] bad_val;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    exp_t exp_q[$];

    risc_run_monitor_if #(.NCH(NCH), .W(W), .CW(CW)) bus ();

    risc_run_monitor #(
        .NCH(NCH), .W(W), .RST_CYCLES(2), .STABLE_CYCLES(4), .MAX_CYCLES(50), .CW(CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    function automatic exp_t mk_exp(input logic p, input logic t, input logic [1:0] m,
                                    input logic [15:0] c, input int at,
                                    input logic [0:0] fb, input logic [31:0] bv);
        exp_t e;
        e.pass      = p;
        e.timeout   = t;
        e.match     = m;
        e.cycles    = c;
        e.done_at   = at;
        e.first_bad = fb;
        e.bad_val   = bv;
        return e;
    endfunction

    // Distinct value every cycle until hold_from, then hold_val; toggle mode alternates two values.
    function automatic logic [63:0] pat(input int k, input int hold_from,
                                        input logic [63:0] hold_val, input bit toggle);
        if (toggle) return k[0] ? {32'h2, 32'h2} : {32'h1, 32'h1};
        if (k >= hold_from) return hold_val;
        return {32'h2000 + 32'(k), 32'h1000 + 32'(k)};
    endfunction

    task automatic check_reset_vals(input string name);
        check({name, "_dut_rst"}, 64'(bus.dut_rst), 64'd1);
        check({name, "_busy"},    64'(bus.busy),    64'd1);
        check({name, "_done"},    64'(bus.done),    64'd0);
        check({name, "_pass"},    64'(bus.pass),    64'd0);
        check({name, "_timeout"}, 64'(bus.timeout), 64'd0);
        check({name, "_match"},   64'(bus.match),   64'd0);
        check({name, "_cycles"},  64'(bus.cycles),  64'd0);
`ifdef RUN_MON_MISMATCH_EN
        check({name, "_first_bad"}, 64'(bus.first_bad), 64'd0);
        check({name, "_bad_val"},   64'(bus.bad_val),   64'd0);
`endif
    endtask

    // Called on the first negedge after the edge that entered RESET_HOLD; returns in RUN cycle 0.
    task automatic hold_len(input string name);
        int n;
        n = 0;
        while (bus.dut_rst === 1'b1 && n < 20) begin
            check({name, "_hold_busy"}, 64'(bus.busy), 64'd1);
            check({name, "_hold_done"}, 64'(bus.done), 64'd0);
            n++;
            @(negedge clk);
        end
        check({name, "_hold_len"}, 64'(n), 64'd2);
        check({name, "_run0_busy"}, 64'(bus.busy), 64'd1);
    endtask

    task automatic rerun_and_hold(input string name);
        bus.rerun = 1'b1;
        @(negedge clk);
        bus.rerun = 1'b0;
        check({name, "_dut_rst"}, 64'(bus.dut_rst), 64'd1);
        check({name, "_busy"},    64'(bus.busy),    64'd1);
        check({name, "_done"},    64'(bus.done),    64'd0);
        check({name, "_pass"},    64'(bus.pass),    64'd0);
        check({name, "_timeout"}, 64'(bus.timeout), 64'd0);
        check({name, "_match"},   64'(bus.match),   64'd0);
        check({name, "_cycles"},  64'(bus.cycles),  64'd0);
        hold_len(name);
    endtask

    // Entered at the negedge of RUN cycle 0; drives one obs value per RUN cycle, then probes DONE freeze.
    task automatic run_scenario(input string name, input int hold_from, input logic [63:0] hold_val,
                                input logic [63:0] exp_v, input logic [1:0] mask_v,
                                input bit toggle, input exp_t e);
        bus.exp  = exp_v;
        bus.mask = mask_v;
        exp_q.push_back(e);
        for (int k = 0; k <= e.done_at + 1; k++) begin
            bus.obs = pat(k, hold_from, hold_val, toggle);
            @(negedge clk);
        end
        for (int j = 0; j < 3; j++) begin
            bus.obs = {32'hDEAD_0000 + 32'(j), 32'hBEEF_0000 + 32'(j)};
            @(negedge clk);
        end
        check({name, "_frozen_done"},    64'(bus.done),    64'd1);
        check({name, "_frozen_busy"},    64'(bus.busy),    64'd0);
        check({name, "_frozen_cycles"},  64'(bus.cycles),  64'(e.cycles));
        check({name, "_frozen_pass"},    64'(bus.pass),    64'(e.pass));
        check({name, "_frozen_match"},   64'(bus.match),   64'(e.match));
        check({name, "_frozen_timeout"}, 64'(bus.timeout), 64'(e.timeout));
    endtask

    // Monitor: counts RUN-relative cycles and scores every rising edge of done.
    initial begin : monitor
        int   run_idx;
        int   n_done;
        logic prev_done;
        exp_t e;
        run_idx   = -1;
        n_done    = 0;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.dut_rst === 1'b1) run_idx = -1;
            else                      run_idx++;
            if (bus.done === 1'b1 && prev_done !== 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 at run cycle %0d, required no result", run_idx);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("r%0d_done_at", n_done), 64'(run_idx),     64'(e.done_at));
                    check($sformatf("r%0d_cycles", n_done),  64'(bus.cycles),  64'(e.cycles));
                    check($sformatf("r%0d_pass", n_done),    64'(bus.pass),    64'(e.pass));
                    check($sformatf("r%0d_timeout", n_done), 64'(bus.timeout), 64'(e.timeout));
                    check($sformatf("r%0d_match", n_done),   64'(bus.match),   64'(e.match));
                    check($sformatf("r%0d_busy", n_done),    64'(bus.busy),    64'd0);
                    check($sformatf("r%0d_dut_rst", n_done), 64'(bus.dut_rst), 64'd0);
`ifdef RUN_MON_MISMATCH_EN
                    check($sformatf("r%0d_first_bad", n_done), 64'(bus.first_bad), 64'(e.first_bad));
                    check($sformatf("r%0d_bad_val", n_done),   64'(bus.bad_val),   64'(e.bad_val));
`endif
                end
                n_done++;
            end
            prev_done = bus.done;
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got no end of run, required finish before 100000 time units");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        bus.rerun = 1'b0;
        bus.obs   = '0;
        bus.exp   = '0;
        bus.mask  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("por");
        rst = 1'b0;
        hold_len("por");

        // Settles from RUN cycle 10: CHECK after cycle 14, cycles=15, done seen in cycle 16.
        run_scenario("clean", 10, {32'hA, 32'h5}, {32'hA, 32'h5}, 2'b11, 1'b0,
                     mk_exp(1'b1, 1'b0, 2'b11, 16'd15, 16, 1'b0, 32'h0));
        rerun_and_hold("rr_clean");
        run_scenario("fail", 10, {32'h6, 32'h5}, {32'hA, 32'h5}, 2'b11, 1'b0,
                     mk_exp(1'b0, 1'b0, 2'b01, 16'd15, 16, 1'b1, 32'h6));
        rerun_and_hold("rr_fail");
        run_scenario("mask", 10, {32'h6, 32'h5}, {32'hA, 32'h5}, 2'b01, 1'b0,
                     mk_exp(1'b1, 1'b0, 2'b11, 16'd15, 16, 1'b0, 32'h0));
        rerun_and_hold("rr_mask");
        // Never settles: DONE on the RUN cycle 49 edge itself.
        run_scenario("timeout", 0, '0, {32'hA, 32'h5}, 2'b11, 1'b1,
                     mk_exp(1'b0, 1'b1, 2'b00, 16'd50, 50, 1'b0, 32'h0));
        rerun_and_hold("rr_timeout");

        // Abort at RUN cycle 20; a rerun pulse at cycle 10 must be ignored.
        for (int k = 0; k < 20; k++) begin
            bus.obs   = pat(k, 1000, '0, 1'b0);
            bus.rerun = (k == 10);
            @(negedge clk);
        end
        bus.rerun = 1'b0;
        check("abort_pre_cycles",  64'(bus.cycles),  64'd20);
        check("abort_pre_dut_rst", 64'(bus.dut_rst), 64'd0);
        check("abort_pre_busy",    64'(bus.busy),    64'd1);
        check("abort_pre_done",    64'(bus.done),    64'd0);
        bus.obs = pat(20, 1000, '0, 1'b0);
        rst     = 1'b1;
        @(negedge clk);
        check_reset_vals("abort");
        rst = 1'b0;
        hold_len("abort_rel");

        // Settles from cycle 45: stability reached on the budget-exhausting edge, so CHECK wins.
        run_scenario("edge49", 45, {32'hA, 32'h5}, {32'hA, 32'h5}, 2'b11, 1'b0,
                     mk_exp(1'b1, 1'b0, 2'b11, 16'd50, 51, 1'b0, 32'h0));

        repeat (2) @(negedge clk);
        check("results_pending", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
